// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and constants for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;
    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // The carry-in node widens the tree to WIDTH+1 nodes, but every sum carry
    // spans at most WIDTH nodes, so log2(WIDTH) levels suffice.
    function automatic int prefix_levels(input int width);
        return clog2(width);
    endfunction
endpackage

// File: rtl/pipelined_prefix_adder_prefix_cell.sv
// Kogge-Stone combine node: merges a higher group (hi) with the adjacent lower group (lo).
module prefix_cell
    import prefix_adder_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);
    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;
endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor, one register bank per prefix level, global stall.
// Define PREFIX_ADDER_FLAGS_EN to add the out_cout / out_ovf flag outputs.
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef PREFIX_ADDER_FLAGS_EN
    ,
    output logic             out_cout,
    output logic             out_ovf
`endif
);
    localparam int L = prefix_levels(WIDTH);

    // Node 0 is the carry-in (bit -1); node i+1 is operand bit i.
    // Bank 0 captures the inputs, bank l holds the output of prefix level l.
    pg_t  [L:0][WIDTH:0]   pg_q, pg_d;
    logic [L:0][WIDTH-1:0] x_q, x_d;
    logic [L:0]            vld_q, vld_d;
    pg_t  [L:1][WIDTH:0]   lvl;
    logic [WIDTH-1:0]      b_eff;
    logic [WIDTH-1:0]      carry;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic                  out_valid_q, out_valid_d;
    logic                  stall;
    logic                  unused_pg;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    for (genvar l = 1; l <= L; l++) begin : g_level
        localparam int D = 1 << (l - 1);
        for (genvar k = 0; k <= WIDTH; k++) begin : g_node
            if (k >= D) begin : g_cell
                prefix_cell u_cell (
                    .hi(pg_q[l-1][k]),
                    .lo(pg_q[l-1][k-D]),
                    .o (lvl[l][k])
                );
            end else begin : g_pass
                assign lvl[l][k] = pg_q[l-1][k];
            end
        end
    end

    always_comb begin
        pg_d  = pg_q;
        x_d   = x_q;
        vld_d = vld_q;
        b_eff = in_sub ? ~in_b : in_b;
        if (!stall) begin
            vld_d[0]   = in_valid;
            x_d[0]     = in_a ^ b_eff;
            pg_d[0][0] = '{g: in_sub | in_cin, p: 1'b0};
            for (int i = 0; i < WIDTH; i++) begin
                pg_d[0][i+1] = '{g: in_a[i] & b_eff[i], p: in_a[i] | b_eff[i]};
            end
            for (int l = 1; l <= L; l++) begin
                vld_d[l] = vld_q[l-1];
                x_d[l]   = x_q[l-1];
                pg_d[l]  = lvl[l];
            end
        end
    end

    // After the last level node i holds the group generate of bits i-1..-1, i.e. c_i.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = pg_q[L][i].g;
        end
        sum_d       = stall ? sum_q : (x_q[L] ^ carry);
        out_valid_d = stall ? out_valid_q : vld_q[L];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_q        <= '0;
            x_q         <= '0;
            vld_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pg_q        <= pg_d;
            x_q         <= x_d;
            vld_q       <= vld_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PREFIX_ADDER_FLAGS_EN
    logic cout_q, cout_d, ovf_q, ovf_d, c_top;

    // Top node spans bits WIDTH-1..0; folding in the carry-in node gives c[WIDTH].
    always_comb begin
        c_top  = pg_q[L][WIDTH].g | (pg_q[L][WIDTH].p & pg_q[L][0].g);
        cout_d = stall ? cout_q : c_top;
        ovf_d  = stall ? ovf_q : (c_top ^ carry[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;
`endif

    assign unused_pg = ^pg_q[L];
    assign out_sum   = sum_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: WIDTH 8/4/32 instances share stimulus, each scored against an arithmetic model.
module tb_pipelined_prefix_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  rdy, ov;
    logic [7:0]  sum8;
    logic [3:0]  sum4;
    logic [31:0] sum32;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic [2:0]  cout, ovf;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(a[7:0]), .in_b(b[7:0]), .in_cin(cin), .in_sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .out_sum(sum8)
`ifdef PREFIX_ADDER_FLAGS_EN
        , .out_cout(cout[0]), .out_ovf(ovf[0])
`endif
    );
    pipelined_prefix_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(a[3:0]), .in_b(b[3:0]), .in_cin(cin), .in_sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .out_sum(sum4)
`ifdef PREFIX_ADDER_FLAGS_EN
        , .out_cout(cout[1]), .out_ovf(ovf[1])
`endif
    );
    pipelined_prefix_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(a), .in_b(b), .in_cin(cin), .in_sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .out_sum(sum32)
`ifdef PREFIX_ADDER_FLAGS_EN
        , .out_cout(cout[2]), .out_ovf(ovf[2])
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum}: plain integer add on zero-extended operands.
    function automatic logic [65:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic ms, input int w);
        logic [63:0] m, aa, bb, full;
        logic        co, ov_s;
        m    = (64'd1 << w) - 64'd1;
        aa   = {32'b0, ma} & m;
        bb   = ms ? (~{32'b0, mb} & m) : ({32'b0, mb} & m);
        full = aa + bb + {63'b0, ms | mc};
        co   = full[w];
        ov_s = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return {ov_s, co, full & m};
    endfunction

    function automatic int wd(input int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 32;
    endfunction

    function automatic logic [31:0] getsum(input int k);
        return (k == 0) ? {24'b0, sum8} : (k == 1) ? {28'b0, sum4} : sum32;
    endfunction

    // Scoreboard: expected results queued at handshake, popped in order at output handshake.
    logic [65:0] exp_mem [3][1024];
    int          wp [3] = '{0, 0, 0};
    int          rp [3] = '{0, 0, 0};
    string       nm [3] = '{"sum_w8", "sum_w4", "sum_w32"};
    logic        held = 1'b0;
    logic [7:0]  held_sum = '0;
    logic [65:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) rp[k] = wp[k];
            held = 1'b0;
        end else begin
            if (held) chk("stall_hold_w8", {55'b0, ov[0], sum8}, {55'b0, 1'b1, held_sum});
            held     = ov[0] && !out_ready;
            held_sum = sum8;
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && out_ready) begin
                    if (rp[k] == wp[k]) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL %s: got unexpected result %0h, expected none", nm[k], getsum(k));
                    end else begin
                        e = exp_mem[k][rp[k] % 1024];
                        rp[k]++;
                        chk(nm[k], {32'b0, getsum(k)}, e[63:0]);
`ifdef PREFIX_ADDER_FLAGS_EN
                        if (k == 0) chk("flags_w8", {62'b0, ovf[0], cout[0]}, {62'b0, e[65:64]});
`endif
                    end
                end
                if (in_valid && rdy[k]) begin
                    exp_mem[k][wp[k] % 1024] = model(a, b, cin, sub, wd(k));
                    wp[k]++;
                end
            end
        end
    end

    // Call only at posedge+1; returns once the W8 instance has taken the beat.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input logic ts, output int tries);
        logic acc;
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance after %0d cycles, expected acceptance", tries);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] sum;
        logic       cout, ovf;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        int          tries, n;
        logic [31:0] hist;
        logic        acc;

        vecs = '{
            '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
            '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
            '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
            '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
            '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0},
            '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0},
            '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
            '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0}
        };

        // Reset state
        #12;
        chk("reset_out_valid", {61'b0, ov}, 64'd0);
        chk("reset_sum_w8", {56'b0, sum8}, 64'd0);
        chk("reset_sum_w32", {32'b0, sum32}, 64'd0);
        chk("reset_in_ready", {61'b0, rdy}, 64'd7);
`ifdef PREFIX_ADDER_FLAGS_EN
        chk("reset_flags", {58'b0, cout, ovf}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, one at a time, with latency check
        for (int i = 0; i < 8; i++) begin
            send({24'b0, vecs[i].a}, {24'b0, vecs[i].b}, vecs[i].cin, vecs[i].sub, tries);
            if (i == 0) chk("first_edge_accept", 64'(tries), 64'd1);
            wait_out(n);
            chk("vec_latency", 64'(n), 64'd4);
            chk("vec_sum", {56'b0, sum8}, {56'b0, vecs[i].sum});
`ifdef PREFIX_ADDER_FLAGS_EN
            chk("vec_flags", {62'b0, cout[0], ovf[0]}, {62'b0, vecs[i].cout, vecs[i].ovf});
`endif
        end
        repeat (10) begin @(posedge clk); #1; end

        // 16 back-to-back random beats: results on 16 consecutive cycles after 4 edges
        hist = '0;
        for (int i = 0; i < 30; i++) begin
            if (i < 16) begin
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            hist[i] = ov[0];
        end
        chk("b2b_valid_pattern", {32'b0, hist}, 64'h000F_FFF0);
        repeat (10) begin @(posedge clk); #1; end

        // Backpressure with 0x42 at the output and a third beat waiting
        out_ready = 1'b0;
        send(32'h40, 32'h02, 1'b0, 1'b0, tries);
        send(32'h01, 32'h01, 1'b0, 1'b0, tries);
        wait_out(n);
        a = 32'h03; b = 32'h04; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_sum", {56'b0, sum8}, 64'h42);
            chk("stall_in_ready", {63'b0, rdy[0]}, 64'd0);
            chk("stall_out_valid", {63'b0, ov[0]}, 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_release_accept", {63'b0, acc}, 64'd1);
        repeat (15) begin @(posedge clk); #1; end

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {61'b0, ov}, 64'd0);
        chk("midreset_in_ready", {61'b0, rdy}, 64'd7);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h10, 32'h20, 1'b0, 1'b0, tries);
        chk("post_reset_accept", 64'(tries), 64'd1);
        wait_out(n);
        chk("post_reset_latency", 64'(n), 64'd4);
        chk("post_reset_sum", {56'b0, sum8}, 64'h30);
        repeat (10) begin @(posedge clk); #1; end

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) begin @(posedge clk); #1; end

        for (int k = 0; k < 3; k++) chk("drained", 64'(wp[k] - rp[k]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected end of test", $time);
        $fatal(1);
    end
endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; power of two, 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-004 SHALL have port in_valid  input  1  operand beat present.
REQ-005 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL have port in_a  input  WIDTH  operand A.
REQ-007 SHALL have port in_b  input  WIDTH  operand B.
REQ-008 SHALL have port in_cin  input  1  carry-in, used when in_sub=0.
REQ-009 SHALL have port in_sub  input  1  1 = subtract (A - B).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_sum  output  WIDTH  result, modulo 2^WIDTH.

Function
REQ-013 SHALL compute out_sum = A + B' + c; add: B' = B, c = in_cin; subtract: B' = ~B, c = 1, in_cin ignored.
REQ-014 SHALL build carries with a Kogge-Stone prefix network of L = log2(WIDTH) levels; p = a|b', g = a&b', carry-in enters as bit -1 generate.
REQ-015 SHALL have one register bank for input capture, one after each prefix level, and one on the output; latency LAT = L+1 edges (WIDTH=8: 4).
REQ-016 SHALL carry a valid bit per bank; bubbles propagate without corrupting neighbours.
REQ-017 SHALL stall globally: stall = out_valid && !out_ready; while stall, all banks, out_sum and out_valid hold.
REQ-018 SHALL drive in_ready = !stall, combinationally.
REQ-019 SHALL sustain one accepted beat per cycle when out_ready=1; results leave in acceptance order.
REQ-020 SHALL keep out_sum stable while out_valid=1 and out_ready=0.
REQ-021 SHALL ignore in_a/in_b/in_cin/in_sub when in_valid=0 or in_ready=0.
REQ-022 SHALL produce the correct full-width wrap on all-ones + 1 (e.g. 0xFF+0x01 = 0x00).

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear all valid bits: out_valid=0, out_sum=0, flags=0.
REQ-024 SHALL discard all in-flight beats on mid-operation reset; none reappear after release.
REQ-025 SHALL hold in_ready=1 during and after reset (stall requires out_valid).
REQ-026 SHALL accept a beat on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with PREFIX_ADDER_FLAGS_EN defined, add outputs out_cout (1, carry out of MSB; in subtract mode 1 = no borrow) and out_ovf (1, signed two's-complement overflow = c[WIDTH] ^ c[WIDTH-1]), both pipelined with out_sum and stall-held.
REQ-028 SHALL, without PREFIX_ADDER_FLAGS_EN, omit both ports and their registers; all other behaviour identical.

Structure
REQ-029 SHALL place in shared package prefix_adder_pkg: clog2 function, level-count constant derivation, and a p/g pair typedef.
REQ-030 SHALL implement the prefix combine as sub-module prefix_cell (G = gi | pi&gj, P = pi&pj), instantiated per node per level.
REQ-031 SHALL produce final sum bit i = a_i ^ b'_i ^ c_i from the last prefix bank.

Verification
REQ-032 SHALL verify (WIDTH=8) add 0xFF+0x01, cin=0 -> out_sum=0x00, out_cout=1, out_ovf=0, out_valid exactly 4 edges after acceptance.
REQ-033 SHALL verify subtract 0x05-0x07, in_cin=1 (ignored) -> 0xFE, out_cout=0, out_ovf=0; and 0x7F+0x01 -> 0x80, out_ovf=1.
REQ-034 SHALL verify 16 back-to-back random beats with out_ready=1 -> 16 results on 16 consecutive cycles, in order, matching a reference model.
REQ-035 SHALL verify out_ready held 0 for 3 cycles with result 0x42 present -> out_sum=0x42 held, in_ready=0, no beat lost or duplicated after release.
REQ-036 SHALL verify rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale result after release, next beat 0x10+0x20 -> 0x30.
REQ-037 SHALL repeat REQ-034 at WIDTH=4 and WIDTH=32 (LAT 3 and 6) and with PREFIX_ADDER_FLAGS_EN undefined.
